// File: rtl/eth_rx_frame_ring.sv
// rtl/eth_rx_frame_ring.sv - receive frame ring: stores AXIS frames into RAM slots, filters on destination MAC
// and commits good frames with their byte length until software releases them.
module eth_rx_frame_ring #(
    parameter int DATA_W    = 8,
    parameter int NBUF      = 8,
    parameter int BUF_BYTES = 2048,
    parameter int LEN_W     = $clog2(BUF_BYTES) + 1,
    parameter int PTR_W     = $clog2(NBUF)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic [47:0]                                      mac_addr_i,
    input  logic                                             promiscuous_i,
    input  logic                                             irq_en_i,
    input  logic [DATA_W-1:0]                                rx_tdata_i,
    input  logic [DATA_W/8-1:0]                              rx_tkeep_i,
    input  logic                                             rx_tvalid_i,
    output logic                                             rx_tready_o,
    input  logic                                             rx_tlast_i,
    input  logic                                             rx_tuser_i,
    output logic                                             mem_we_o,
    output logic [PTR_W+$clog2(BUF_BYTES/(DATA_W/8))-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]                                mem_wdata_o,
    output logic [DATA_W/8-1:0]                              mem_be_o,
    input  logic                                             release_i,
    input  logic [PTR_W-1:0]                                 len_idx_i,
    output logic [LEN_W-1:0]                                 len_o,
    output logic [PTR_W-1:0]                                 head_o,
    output logic [PTR_W-1:0]                                 tail_o,
    output logic [PTR_W:0]                                   count_o,
    output logic                                             avail_o,
    output logic                                             irq_o,
    output logic [15:0]                                      drop_cnt_o
);
    localparam int BEAT  = DATA_W / 8;
    localparam int IDX_W = $clog2(BUF_BYTES / BEAT);
    localparam logic [LEN_W:0] MAX_BYTES = (LEN_W+1)'(BUF_BYTES);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(NBUF);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT, S_DISCARD} state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          head_q, tail_q;
    logic [PTR_W:0]            count_q, count_d;
    logic [LEN_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]          beat_idx_q;
    logic                      ovf_q, ovf_d, err_q;
    logic [47:0]               dest_q, dest_d;
    logic [LEN_W-1:0]          len_q [NBUF];
    logic [15:0]               drop_q;
    logic                      tready_q, irq_q, mem_we_q;
    logic [PTR_W+IDX_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]         mem_wdata_q;
    logic [BEAT-1:0]           mem_be_q;

    logic                      beat, full, first, store, wr_beat;
    logic                      bad, filt_ok, accept, rel, drop_inc;
    logic [LEN_W-1:0]          base_cnt, beat_bytes;
    logic [IDX_W-1:0]          base_idx;
    logic [LEN_W:0]            sum;
    int                        pos;

    // The first beat of a frame is accounted from zero in IDLE, so IDLE and RECV share one beat path.
    always_comb begin
        beat     = rx_tvalid_i & tready_q;
        full     = (count_q == FULL_CNT);
        first    = (state_q == S_IDLE);
        store    = beat & ((first & ~full) | (state_q == S_RECV));
        base_cnt = first ? '0 : byte_cnt_q;
        base_idx = first ? '0 : beat_idx_q;
        beat_bytes = '0;
        for (int k = 0; k < BEAT; k++) begin
            beat_bytes = beat_bytes + LEN_W'(rx_tkeep_i[k]);
        end
        sum        = {1'b0, base_cnt} + {1'b0, beat_bytes};
        ovf_d      = (~first & ovf_q) | (sum > MAX_BYTES);
        wr_beat    = store & ~ovf_d;
        byte_cnt_d = ovf_d ? base_cnt : sum[LEN_W-1:0];
        dest_d     = first ? '0 : dest_q;
        pos        = 0;
        for (int k = 0; k < BEAT; k++) begin
            pos = int'(base_cnt) + k;
            if (rx_tkeep_i[k] && pos < 6) begin
                dest_d[8*(5-pos) +: 8] = rx_tdata_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        bad      = (byte_cnt_q < LEN_W'(6)) | err_q | ovf_q;
        filt_ok  = promiscuous_i | (dest_q == mac_addr_i) | (&dest_q) |
                   (dest_q[47:24] == 24'h01005E);
        accept   = (state_q == S_COMMIT) & ~bad & filt_ok;
        rel      = release_i & (count_q != '0);
        count_d  = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(rel);
        // Filter misses are silently recycled; only runt/error/overflow/ring-full count as drops.
        drop_inc = ((state_q == S_COMMIT) & bad) |
                   (beat & rx_tlast_i & ((state_q == S_DISCARD) | (first & full)));
        state_d  = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (full) state_d = rx_tlast_i ? S_IDLE : S_DISCARD;
                    else      state_d = rx_tlast_i ? S_COMMIT : S_RECV;
                end
            end
            S_RECV:    if (beat && rx_tlast_i) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            S_DISCARD: if (beat && rx_tlast_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            byte_cnt_q  <= '0;
            beat_idx_q  <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            dest_q      <= '0;
            drop_q      <= '0;
            tready_q    <= 1'b1;
            irq_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d != S_COMMIT);
            mem_we_q <= wr_beat;
            mem_be_q <= wr_beat ? rx_tkeep_i : '0;
            if (wr_beat) begin
                mem_addr_q  <= {head_q, base_idx};
                mem_wdata_q <= rx_tdata_i;
            end
            if (store) begin
                byte_cnt_q <= byte_cnt_d;
                beat_idx_q <= base_idx + IDX_W'(1);
                ovf_q      <= ovf_d;
                dest_q     <= dest_d;
                if (rx_tlast_i) err_q <= rx_tuser_i;
            end
            if (accept) begin
                len_q[head_q] <= byte_cnt_q;
                head_q        <= head_q + PTR_W'(1);
            end
            if (rel) tail_q <= tail_q + PTR_W'(1);
            count_q <= count_d;
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            irq_q <= (count_d != '0) & irq_en_i;
        end
    end

    assign rx_tready_o = tready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign len_o       = len_q[len_idx_i];
    assign head_o      = head_q;
    assign tail_o      = tail_q;
    assign count_o     = count_q;
    assign avail_o     = (count_q != '0);
    assign irq_o       = irq_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_eth_rx_frame_ring.sv
// tb/tb_eth_rx_frame_ring.sv - directed bench for eth_rx_frame_ring at DATA_W=8 and DATA_W=64
module tb_eth_rx_frame_ring;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [47:0] mac = 48'h020000000001;
    logic promisc, irq_en;

    logic [7:0]  a_tdata;  logic [0:0] a_tkeep;  logic a_tvalid, a_tlast, a_tuser, a_tready;
    logic a_we; logic [13:0] a_addr; logic [7:0] a_wdata; logic [0:0] a_be;
    logic a_rel; logic [2:0] a_lidx; logic [11:0] a_len; logic [2:0] a_head, a_tail;
    logic [3:0] a_count; logic a_avail, a_irq; logic [15:0] a_drop;

    logic [63:0] b_tdata;  logic [7:0] b_tkeep;  logic b_tvalid, b_tlast, b_tuser, b_tready;
    logic b_we; logic [10:0] b_addr; logic [63:0] b_wdata; logic [7:0] b_be;
    logic b_rel; logic [2:0] b_lidx; logic [11:0] b_len; logic [2:0] b_head, b_tail;
    logic [3:0] b_count; logic b_avail, b_irq; logic [15:0] b_drop;

    eth_rx_frame_ring #(.DATA_W(8), .NBUF(8), .BUF_BYTES(2048)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .mac_addr_i(mac), .promiscuous_i(promisc), .irq_en_i(irq_en),
        .rx_tdata_i(a_tdata), .rx_tkeep_i(a_tkeep), .rx_tvalid_i(a_tvalid), .rx_tready_o(a_tready),
        .rx_tlast_i(a_tlast), .rx_tuser_i(a_tuser), .mem_we_o(a_we), .mem_addr_o(a_addr),
        .mem_wdata_o(a_wdata), .mem_be_o(a_be), .release_i(a_rel), .len_idx_i(a_lidx), .len_o(a_len),
        .head_o(a_head), .tail_o(a_tail), .count_o(a_count), .avail_o(a_avail), .irq_o(a_irq),
        .drop_cnt_o(a_drop));

    eth_rx_frame_ring #(.DATA_W(64), .NBUF(8), .BUF_BYTES(2048)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .mac_addr_i(mac), .promiscuous_i(promisc), .irq_en_i(irq_en),
        .rx_tdata_i(b_tdata), .rx_tkeep_i(b_tkeep), .rx_tvalid_i(b_tvalid), .rx_tready_o(b_tready),
        .rx_tlast_i(b_tlast), .rx_tuser_i(b_tuser), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_wdata_o(b_wdata), .mem_be_o(b_be), .release_i(b_rel), .len_idx_i(b_lidx), .len_o(b_len),
        .head_o(b_head), .tail_o(b_tail), .count_o(b_count), .avail_o(b_avail), .irq_o(b_irq),
        .drop_cnt_o(b_drop));

    logic [13:0] a_wa[$]; logic [7:0] a_wd[$];
    logic [10:0] b_wa[$]; logic [7:0] b_wbe[$];
    logic [7:0] fb [0:2111];

    always @(negedge clk) begin
        if (a_we) begin a_wa.push_back(a_addr); a_wd.push_back(a_wdata); end
        if (b_we) begin b_wa.push_back(b_addr); b_wbe.push_back(b_be); end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input logic [47:0] d, input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'(i * 3 + 1);
        for (int i = 0; i < 6; i++) fb[i] = d[47-8*i -: 8];
    endtask

    task automatic hs_a();
        logic rdy;
        for (int t = 0; t < 20; t++) begin
            rdy = a_tready;
            @(posedge clk); #1;
            if (rdy) return;
        end
        tests++; fails++; $display("FAIL hs_a: tready got 0 required 1 within 20 cycles");
    endtask

    task automatic hs_b();
        logic rdy;
        for (int t = 0; t < 20; t++) begin
            rdy = b_tready;
            @(posedge clk); #1;
            if (rdy) return;
        end
        tests++; fails++; $display("FAIL hs_b: tready got 0 required 1 within 20 cycles");
    endtask

    task automatic send_a(input int n, input bit err);
        for (int i = 0; i < n; i++) begin
            a_tvalid = 1'b1; a_tdata = fb[i]; a_tkeep = 1'b1;
            a_tlast = (i == n - 1); a_tuser = err && (i == n - 1);
            hs_a();
        end
        a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
    endtask

    task automatic send_b(input int n, input bit err);
        int nb;
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            int rem;
            rem = n - 8 * b;
            for (int k = 0; k < 8; k++) b_tdata[8*k +: 8] = (k < rem) ? fb[8*b+k] : 8'h00;
            b_tkeep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            b_tvalid = 1'b1; b_tlast = (b == nb - 1); b_tuser = err && (b == nb - 1);
            hs_b();
        end
        b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (a_head !== 3'd0 || a_tail !== 3'd0 || a_count !== 4'd0) begin fails++;
            $display("FAIL reset_ptrs8: got h%0d t%0d c%0d required 0 0 0", a_head, a_tail, a_count); end
        tests++; if (a_tready !== 1'b1 || a_we !== 1'b0 || a_be !== 1'b0) begin fails++;
            $display("FAIL reset_ctl8: got rdy%b we%b be%b required 1 0 0", a_tready, a_we, a_be); end
        tests++; if (a_irq !== 1'b0 || a_avail !== 1'b0 || a_drop !== 16'd0) begin fails++;
            $display("FAIL reset_misc8: got irq%b av%b drop%0d required 0 0 0", a_irq, a_avail, a_drop); end
        tests++; if (a_len !== 12'd0) begin fails++; $display("FAIL reset_len8: got %0d required 0", a_len); end
        tests++; if (b_head !== 3'd0 || b_count !== 4'd0 || b_tready !== 1'b1 || b_be !== 8'h00) begin fails++;
            $display("FAIL reset_64: got h%0d c%0d rdy%b be%h required 0 0 1 00", b_head, b_count, b_tready, b_be); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_basic();
        int bad;
        bad = 0;
        set_hdr(mac, 64);
        a_wa.delete(); a_wd.delete();
        send_a(64, 1'b0);
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL basic_irq_commit: got %b required 0", a_irq); end
        cyc(1);
        tests++; if (a_irq !== 1'b1) begin fails++; $display("FAIL basic_irq_after: got %b required 1", a_irq); end
        tests++; if (a_head !== 3'd1 || a_count !== 4'd1 || a_avail !== 1'b1) begin fails++;
            $display("FAIL basic_ptrs: got h%0d c%0d av%b required 1 1 1", a_head, a_count, a_avail); end
        a_lidx = 3'd0; #1;
        tests++; if (a_len !== 12'd64) begin fails++; $display("FAIL basic_len: got %0d required 64", a_len); end
        tests++; if (a_wa.size() !== 64) begin fails++; $display("FAIL basic_wr_count: got %0d required 64", a_wa.size()); end
        for (int i = 0; i < a_wa.size(); i++) if (a_wa[i] !== 14'(i) || a_wd[i] !== fb[i]) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL basic_wr_content: got %0d bad writes required 0", bad); end
    endtask

    task automatic test_filter();
        set_hdr(48'h020000000002, 60); send_a(60, 1'b0); cyc(2);
        tests++; if (a_head !== 3'd1 || a_drop !== 16'd0) begin fails++;
            $display("FAIL filter_miss: got h%0d drop%0d required 1 0", a_head, a_drop); end
        promisc = 1'b1; send_a(60, 1'b0); cyc(2); promisc = 1'b0;
        tests++; if (a_head !== 3'd2) begin fails++; $display("FAIL filter_promisc: got head %0d required 2", a_head); end
        set_hdr(48'hFFFFFFFFFFFF, 60); send_a(60, 1'b0); cyc(2);
        tests++; if (a_head !== 3'd3) begin fails++; $display("FAIL filter_bcast: got head %0d required 3", a_head); end
        set_hdr(48'h01005E000001, 33); send_a(33, 1'b0); cyc(2);
        tests++; if (a_head !== 3'd4 || a_count !== 4'd4) begin fails++;
            $display("FAIL filter_mcast: got h%0d c%0d required 4 4", a_head, a_count); end
        a_lidx = 3'd3; #1;
        tests++; if (a_len !== 12'd33) begin fails++; $display("FAIL filter_len3: got %0d required 33", a_len); end
    endtask

    task automatic test_full();
        set_hdr(mac, 20);
        for (int i = 0; i < 4; i++) begin send_a(20, 1'b0); cyc(2); end
        tests++; if (a_count !== 4'd8 || a_head !== 3'd0) begin fails++;
            $display("FAIL full_fill: got c%0d h%0d required 8 0", a_count, a_head); end
        a_wa.delete(); send_a(20, 1'b0); cyc(2);
        tests++; if (a_wa.size() !== 0) begin fails++; $display("FAIL full_no_write: got %0d writes required 0", a_wa.size()); end
        tests++; if (a_drop !== 16'd1 || a_head !== 3'd0 || a_count !== 4'd8) begin fails++;
            $display("FAIL full_drop: got drop%0d h%0d c%0d required 1 0 8", a_drop, a_head, a_count); end
        irq_en = 1'b0; cyc(1);
        tests++; if (a_irq !== 1'b0) begin fails++; $display("FAIL irq_en_off: got %b required 0", a_irq); end
        irq_en = 1'b1; cyc(1);
        tests++; if (a_irq !== 1'b1) begin fails++; $display("FAIL irq_en_on: got %b required 1", a_irq); end
        a_rel = 1'b1; cyc(1); a_rel = 1'b0;
        tests++; if (a_tail !== 3'd1 || a_count !== 4'd7) begin fails++;
            $display("FAIL full_release: got t%0d c%0d required 1 7", a_tail, a_count); end
        set_hdr(mac, 25); a_wa.delete(); send_a(25, 1'b0); cyc(2);
        tests++; if (a_wa.size() != 25 || a_wa[0] !== 14'd0) begin fails++;
            $display("FAIL full_reuse_slot0: got %0d writes required 25 starting at addr 0", a_wa.size()); end
        a_lidx = 3'd0; #1;
        tests++; if (a_len !== 12'd25 || a_head !== 3'd1 || a_tail !== 3'd1 || a_count !== 4'd8) begin fails++;
            $display("FAIL full_reuse_state: got len%0d h%0d t%0d c%0d required 25 1 1 8", a_len, a_head, a_tail, a_count); end
        for (int i = 0; i < 8; i++) begin a_rel = 1'b1; cyc(1); a_rel = 1'b0; end
        tests++; if (a_count !== 4'd0 || a_tail !== 3'd1) begin fails++;
            $display("FAIL drain: got c%0d t%0d required 0 1", a_count, a_tail); end
        a_rel = 1'b1; cyc(1); a_rel = 1'b0; cyc(1);
        tests++; if (a_count !== 4'd0 || a_tail !== 3'd1 || a_irq !== 1'b0) begin fails++;
            $display("FAIL release_empty: got c%0d t%0d irq%b required 0 1 0", a_count, a_tail, a_irq); end
    endtask

    task automatic test_release_commit();
        set_hdr(mac, 20); send_a(20, 1'b0); cyc(2);
        tests++; if (a_count !== 4'd1 || a_head !== 3'd2) begin fails++;
            $display("FAIL relc_pre: got c%0d h%0d required 1 2", a_count, a_head); end
        send_a(20, 1'b0);
        a_rel = 1'b1; cyc(1); a_rel = 1'b0;
        tests++; if (a_count !== 4'd1 || a_head !== 3'd3 || a_tail !== 3'd2) begin fails++;
            $display("FAIL relc_same_cycle: got c%0d h%0d t%0d required 1 3 2", a_count, a_head, a_tail); end
    endtask

    task automatic test_wide();
        set_hdr(mac, 61); b_wa.delete(); b_wbe.delete(); send_b(61, 1'b0); cyc(2);
        tests++; if (b_wa.size() != 8 || b_wbe[7] !== 8'h1F) begin fails++;
            $display("FAIL wide_writes: got %0d writes required 8 with last be 1f", b_wa.size()); end
        b_lidx = 3'd0; #1;
        tests++; if (b_len !== 12'd61 || b_head !== 3'd1) begin fails++;
            $display("FAIL wide_len: got len%0d h%0d required 61 1", b_len, b_head); end
        set_hdr(mac, 2049); b_wa.delete(); send_b(2049, 1'b0); cyc(2);
        tests++; if (b_wa.size() !== 256) begin fails++; $display("FAIL ovf_writes: got %0d required 256", b_wa.size()); end
        tests++; if (b_drop !== 16'd1 || b_head !== 3'd1) begin fails++;
            $display("FAIL ovf_drop: got drop%0d h%0d required 1 1", b_drop, b_head); end
        set_hdr(mac, 64); send_b(64, 1'b1); cyc(2);
        tests++; if (b_drop !== 16'd2 || b_head !== 3'd1) begin fails++;
            $display("FAIL err_drop: got drop%0d h%0d required 2 1", b_drop, b_head); end
        set_hdr(mac, 4); send_b(4, 1'b0); cyc(2);
        tests++; if (b_drop !== 16'd3 || b_head !== 3'd1 || b_count !== 4'd1) begin fails++;
            $display("FAIL runt_drop: got drop%0d h%0d c%0d required 3 1 1", b_drop, b_head, b_count); end
    endtask

    task automatic test_reset_mid();
        set_hdr(48'h0, 64);
        for (int i = 0; i < 6; i++) fb[24+i] = mac[47-8*i -: 8];
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 8; k++) b_tdata[8*k +: 8] = fb[8*b+k];
            b_tkeep = 8'hFF; b_tvalid = 1'b1; b_tlast = 1'b0; b_tuser = 1'b0;
            hs_b();
        end
        for (int k = 0; k < 8; k++) b_tdata[8*k +: 8] = fb[24+k];
        #2; rst_n = 1'b0; #1;
        tests++; if (b_head !== 3'd0 || b_count !== 4'd0 || b_drop !== 16'd0 || b_irq !== 1'b0) begin fails++;
            $display("FAIL midrst_state: got h%0d c%0d drop%0d irq%b required 0 0 0 0", b_head, b_count, b_drop, b_irq); end
        tests++; if (b_we !== 1'b0 || b_tready !== 1'b1 || b_len !== 12'd0) begin fails++;
            $display("FAIL midrst_ctl: got we%b rdy%b len%0d required 0 1 0", b_we, b_tready, b_len); end
        tests++; if (a_head !== 3'd0 || a_tail !== 3'd0 || a_count !== 4'd0) begin fails++;
            $display("FAIL midrst_dut8: got h%0d t%0d c%0d required 0 0 0", a_head, a_tail, a_count); end
        b_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cyc(1);
        for (int i = 0; i < 40; i++) fb[i] = fb[24+i];
        b_wa.delete(); send_b(40, 1'b0); cyc(2);
        tests++; if (b_wa.size() != 5 || b_wa[0] !== 11'd0) begin fails++;
            $display("FAIL midrst_remainder: got %0d writes required 5 starting at addr 0", b_wa.size()); end
        tests++; if (b_len !== 12'd40 || b_head !== 3'd1) begin fails++;
            $display("FAIL midrst_commit: got len%0d h%0d required 40 1", b_len, b_head); end
    endtask

    initial begin
        promisc = 1'b0; irq_en = 1'b1;
        a_tdata = '0; a_tkeep = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0; a_rel = 1'b0; a_lidx = '0;
        b_tdata = '0; b_tkeep = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0; b_rel = 1'b0; b_lidx = '0;
        cyc(3);
        test_reset();
        test_basic();
        test_filter();
        test_full();
        test_release_commit();
        test_wide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
